// File: rtl/regfile_dump_reader_if.sv
// Register-file read port plus the valid/ready presentation channel of the dump reader.
interface regfile_dump_reader_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output rd_addr, out_valid, out_addr, out_data,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_addr, out_valid, out_addr, out_data,
    output rd_data, out_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks every register through the register-file read port, presents each value on a
// valid/ready channel and mirrors it on the board LEDs for a fixed dwell time.
module regfile_dump_reader #(
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 4,
  parameter int DWELL    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  regfile_dump_reader_if.master        bus,
  output logic                         busy,
  output logic                         done,
  output logic [7:0]                   led
);

  localparam int                CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]  DWELL_LOAD = CNT_W'(DWELL - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SHOW,
    HOLD,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      bus.rd_addr   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_addr  <= '0;
      bus.out_data  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= READ;
            idx         <= '0;
            bus.rd_addr <= '0;
            busy        <= 1'b1;
          end
        end
        READ: begin
          // rd_addr has been stable on idx for this whole cycle, so rd_data is settled
          bus.out_data  <= bus.rd_data;
          bus.out_addr  <= idx;
          bus.out_valid <= 1'b1;
          state         <= SHOW;
        end
        SHOW: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            cnt           <= DWELL_LOAD;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            if (idx == LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx         <= idx + 1'b1;
              bus.rd_addr <= idx + 1'b1;
              state       <= READ;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pure wiring of registered signals; bits between out_valid and out_addr stay zero.
  always_comb begin
    led                          = '0;
    led[7]                       = busy;
    led[6]                       = bus.out_valid;
    led[ADDR_W+DATA_W-1:0]       = {bus.out_addr, bus.out_data};
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: directed scenarios plus random traffic, all checked
// against a timeline model of the dump (event cycles computed from the dwell rules).
module tb_regfile_dump_reader;

  localparam int ADDR_W   = 2;
  localparam int DATA_W   = 4;
  localparam int NUM_REGS = 4;
  localparam int DWELL    = 4;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic [7:0]        led;
  logic [DATA_W-1:0] regs [NUM_REGS];

  regfile_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  assign bus.rd_data = regs[bus.rd_addr];

  regfile_dump_reader #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .DWELL   (DWELL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .bus  (bus),
    .busy (busy),
    .done (done),
    .led  (led)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Model: visible outputs plus the cycle of the next READ (or DONE) event.
  bit m_busy, m_valid, m_done, ev_is_done;
  int m_addr, m_data, k, ev_at;

  // Observations taken from the DUT after every edge.
  int  obs_done, obs_hs, last_done_cyc;
  bit  prev_valid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_valid = 0; m_done = 0; ev_is_done = 0;
    m_addr = 0; m_data = 0; k = 0; ev_at = 0;
  endtask

  // Advance the model across the edge that ends cycle cyc, using the inputs now applied.
  task automatic model_step();
    if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; k = 0; ev_at = cyc + 1; ev_is_done = 0;
      end
    end else if (m_valid) begin
      if (bus.out_ready) begin
        $display("xfer cyc=%0d addr=%0d data=%h", cyc, m_addr, m_data);
        m_valid = 0;
        ev_at   = cyc + 1 + DWELL;
        if (k == NUM_REGS - 1) ev_is_done = 1;
        else k++;
      end
    end else if (!ev_is_done && cyc == ev_at) begin
      m_valid = 1; m_addr = k; m_data = int'(regs[k]);
    end else if (ev_is_done && cyc + 1 == ev_at) begin
      m_done = 1;
    end
  endtask

  task automatic compare_all();
    check_eq("busy", busy, m_busy);
    check_eq("done", done, m_done);
    check_eq("out_valid", bus.out_valid, m_valid);
    check_eq("out_addr", bus.out_addr, m_addr);
    check_eq("out_data", bus.out_data, m_data);
    check_eq("led", led, m_busy * 128 + m_valid * 64 + m_addr * 16 + m_data);
    if (m_busy && !m_valid && !m_done && !ev_is_done && cyc == ev_at)
      check_eq("rd_addr", bus.rd_addr, k);
  endtask

  task automatic cycle(input bit st, input bit rdy, input bit we = 0,
                       input int wa = 0, input int wd = 0);
    @(negedge clk);
    compare_all();
    start         = st;
    bus.out_ready = rdy;
    if (we) regs[wa] = DATA_W'(wd);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin
      obs_done++;
      last_done_cyc = cyc;
    end
    if (prev_valid && !bus.out_valid) obs_hs++;
    prev_valid = bus.out_valid;
  endtask

  task automatic clear_obs();
    obs_done = 0; obs_hs = 0; last_done_cyc = -1; prev_valid = bus.out_valid;
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_addr", bus.out_addr, 0);
    check_eq("rst_data", bus.out_data, 0);
    check_eq("rst_rd_addr", bus.rd_addr, 0);
    check_eq("rst_led", led, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_default_regs();
    regs[0] = 4'h3; regs[1] = 4'hA; regs[2] = 4'h5; regs[3] = 4'hF;
  endtask

  initial begin
    int c0;
    int prev_done;
    int busy_low;
    bus.out_ready = 1'b1;
    load_default_regs();
    #2;
    do_reset();

    // Nominal dump with out_ready high.
    clear_obs();
    c0 = cyc;
    cycle(1, 1);
    repeat (34) cycle(0, 1);
    check_eq("s1_done_lat", last_done_cyc - c0, 25);
    check_eq("s1_handshakes", obs_hs, 4);
    check_eq("s1_done_count", obs_done, 1);

    // Consumer stalls the first SHOW for 10 cycles.
    clear_obs();
    c0 = cyc;
    cycle(1, 1);
    for (int i = 1; i < 45; i++) begin
      cycle(0, !(cyc >= c0 + 2 && cyc < c0 + 12));
      if (cyc >= c0 + 2 && cyc < c0 + 12) begin
        check_eq("s2_stall_valid", bus.out_valid, 1);
        check_eq("s2_stall_data", bus.out_data, 4'h3);
      end
    end
    check_eq("s2_done_lat", last_done_cyc - c0, 35);

    // Start pulses while busy (including the DONE cycle) are ignored.
    clear_obs();
    c0 = cyc;
    for (int i = 0; i < 40; i++) cycle(i == 0 || i == 5 || i == 25, 1);
    check_eq("s3_handshakes", obs_hs, 4);
    check_eq("s3_done_count", obs_done, 1);

    // Writes during the dump: reg1 before its READ, reg0 after its capture.
    clear_obs();
    c0 = cyc;
    for (int i = 0; i < 35; i++) begin
      cycle(i == 0, 1, i == 3 || i == 4, (i == 3) ? 1 : 0, (i == 3) ? 7 : 9);
      if (cyc == c0 + 2) check_eq("s4_reg0", bus.out_data, 4'h3);
      if (cyc == c0 + 8) check_eq("s4_reg1", bus.out_data, 4'h7);
    end
    load_default_regs();

    // Asynchronous reset mid-dump, then a clean restart.
    clear_obs();
    c0 = cyc;
    for (int i = 0; i < 10; i++) cycle(i == 0, 1);
    #2;
    do_reset();
    check_eq("s5_no_done", obs_done, 0);
    clear_obs();
    c0 = cyc;
    for (int i = 0; i < 30; i++) begin
      cycle(i == 0, 1);
      if (cyc == c0 + 2) check_eq("s5_restart_addr", bus.out_addr, 0);
    end

    // start held high: back-to-back dumps every 26 cycles, one idle cycle between.
    clear_obs();
    c0        = cyc;
    prev_done = -1;
    busy_low  = 0;
    for (int i = 0; i < 90; i++) begin
      cycle(1, 1);
      if (done) begin
        if (prev_done >= 0) check_eq("s6_period", cyc - prev_done, 26);
        prev_done = cyc;
      end
      if (!busy && cyc > c0 + 25 && cyc < c0 + 77) busy_low++;
    end
    check_eq("s6_done_count", obs_done, 3);
    check_eq("s6_busy_gaps", busy_low, 2);
    repeat (30) cycle(0, 1);

    // Random traffic: sporadic starts, random back-pressure and register writes.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, int'($urandom_range(0, NUM_REGS - 1)),
            int'($urandom_range(0, 15)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
